// File: rtl/axicb_scfifo_pkg.sv
// Shared types for the single-clock FIFO controller and its RAM.
// Output-stage FSM states are only used when AXICB_SCFIFO_OUT_REG_EN is defined.
package axicb_scfifo_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/axicb_scfifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, read either
// combinational (FFD_EN=0) or registered (FFD_EN=1). Contents are never reset.
module axicb_scfifo_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FFD_EN     = 0
) (
    input  logic                  aclk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[addr_in] <= data_in;
        end
    end

    generate
        if (FFD_EN != 0) begin : g_rd_reg
            always_ff @(posedge aclk) begin
                data_out <= mem[addr_out];
            end
        end else begin : g_rd_comb
            assign data_out = mem[addr_out];
        end
    endgenerate

endmodule

// File: rtl/axicb_scfifo_ctrl.sv
// Single-clock FIFO controller: owns pointers, flags and fill level for axicb_scfifo_ram.
// Define AXICB_SCFIFO_OUT_REG_EN for a registered output stage (one extra word of capacity).
module axicb_scfifo_ctrl
    import axicb_scfifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                      (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count    = wr_ptr - rd_ptr;
    assign afull    = (count >= AFULL_LVL);
    assign in_ready = !full;
    // Full blocks writes even when a pop lands in the same cycle.
    assign push     = in_valid && !full;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    axicb_scfifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FFD_EN     (0)
    ) u_ram (
        .aclk     (aclk),
        .wr_en    (push),
        .addr_in  (wr_ptr[ADDR_WIDTH-1:0]),
        .data_in  (in_data),
        .addr_out (rd_ptr[ADDR_WIDTH-1:0]),
        .data_out (ram_rdata)
    );

`ifdef AXICB_SCFIFO_OUT_REG_EN
    out_state_t state;

    // A fetch moves the RAM head into the output register.
    assign pop       = !empty && ((state == OUT_EMPTY) || out_ready);
    assign out_valid = (state == OUT_FULL);

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state    <= OUT_EMPTY;
            out_data <= '0;
        end else if (pop) begin
            state    <= OUT_FULL;
            out_data <= ram_rdata;
        end else if ((state == OUT_FULL) && out_ready) begin
            state    <= OUT_EMPTY;
        end
    end
`else
    assign out_valid = !empty;
    assign out_data  = ram_rdata;
    assign pop       = out_valid && out_ready;
`endif

endmodule

// File: tb/tb_axicb_scfifo_ctrl.sv
// Directed bench for axicb_scfifo_ctrl at ADDR_WIDTH=2, AFULL_THRESH=3;
// expectations follow AXICB_SCFIFO_OUT_REG_EN when it is defined.
module tb_axicb_scfifo_ctrl;

    logic       aclk = 1'b0;
    logic       arst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       full, empty, afull;
    logic [2:0] count;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axicb_scfifo_ctrl #(
        .ADDR_WIDTH   (2),
        .DATA_WIDTH   (8),
        .AFULL_THRESH (3)
    ) dut (
        .aclk      (aclk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .full      (full),
        .empty     (empty),
        .afull     (afull),
        .count     (count)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic       chk_d;
        logic [7:0] e_d;
        logic [2:0] e_cnt;
        logic       e_emp;
        logic       e_full;
        logic       e_af;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [7:0] id, logic ordy, logic e_ir, logic e_ov,
                                logic chk_d, logic [7:0] e_d, logic [2:0] e_cnt,
                                logic e_emp, logic e_full, logic e_af);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
        v.chk_d = chk_d; v.e_d = e_d; v.e_cnt = e_cnt;
        v.e_emp = e_emp; v.e_full = e_full; v.e_af = e_af;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge aclk);
        arst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge aclk);
        arst = 1'b0;
    endtask

    // Pushes until count reaches n; leaves time at a negedge with inputs idle.
    task automatic push_until(input logic [2:0] n, input logic ordy, input logic [7:0] base);
        logic [7:0] d;
        d = base;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (count == n) break;
            in_valid = 1'b1;
            in_data = d;
            out_ready = ordy;
            d = d + 8'h01;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("push_until.count", 32'(count), 32'(n));
    endtask

    initial begin
        logic [7:0] exp_d;
        logic [7:0] tx_d;
        int rx;
        int tx;
        logic got;

        // reset state
        @(negedge aclk);
        @(negedge aclk);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.afull", 32'(afull), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
`ifdef AXICB_SCFIFO_OUT_REG_EN
        chk("rst.out_data", 32'(out_data), 32'd0);
`endif
        arst = 1'b0;

        // fill with out_ready low, then drain
`ifdef AXICB_SCFIFO_OUT_REG_EN
        tbl.push_back(mk(1, 8'hA0, 0, 1, 0, 0, 8'h00, 3'd1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA1, 0, 1, 1, 1, 8'hA0, 3'd1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA2, 0, 1, 1, 1, 8'hA0, 3'd2, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA3, 0, 1, 1, 1, 8'hA0, 3'd3, 0, 0, 1));
        tbl.push_back(mk(1, 8'hA4, 0, 0, 1, 1, 8'hA0, 3'd4, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA1, 3'd3, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA2, 3'd2, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA3, 3'd1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA4, 3'd0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 3'd0, 1, 0, 0));
`else
        tbl.push_back(mk(1, 8'hA0, 0, 1, 1, 1, 8'hA0, 3'd1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA1, 0, 1, 1, 1, 8'hA0, 3'd2, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA2, 0, 1, 1, 1, 8'hA0, 3'd3, 0, 0, 1));
        tbl.push_back(mk(1, 8'hA3, 0, 0, 1, 1, 8'hA0, 3'd4, 0, 1, 1));
        tbl.push_back(mk(1, 8'hA4, 0, 0, 1, 1, 8'hA0, 3'd4, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA1, 3'd3, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA2, 3'd2, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hA3, 3'd1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 3'd0, 1, 0, 0));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge aclk);
            in_valid = tbl[i].iv;
            in_data = tbl[i].id;
            out_ready = tbl[i].ordy;
            @(posedge aclk);
            #1;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].chk_d)
                chk($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(tbl[i].e_d));
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(tbl[i].e_emp));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(tbl[i].e_full));
            chk($sformatf("vec%0d.afull", i), 32'(afull), 32'(tbl[i].e_af));
        end

        // back-to-back traffic across pointer wrap
        reset_dut();
        rx = 0;
        tx = 0;
        for (int cyc = 0; cyc < 30 && rx < 10; cyc++) begin
            if (cyc != 0) @(negedge aclk);
            tx_d = 8'hB0 + 8'(tx);
            in_valid = (tx < 10);
            in_data = tx_d;
            out_ready = 1'b1;
            #1;
            if (full) chk("wrap.full", 32'(full), 32'd0);
            if (out_valid) begin
                exp_d = 8'hB0 + 8'(rx);
                chk($sformatf("wrap.data%0d", rx), 32'(out_data), 32'(exp_d));
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        chk("wrap.received", 32'(rx), 32'd10);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // simultaneous push+pop at count 3, then at full
        reset_dut();
        push_until(3'd3, 1'b0, 8'hC0);
        in_valid = 1'b1;
        in_data = 8'hCA;
        out_ready = 1'b1;
        @(posedge aclk);
        #1;
        chk("pp3.count", 32'(count), 32'd3);
        chk("pp3.afull", 32'(afull), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        push_until(3'd4, 1'b0, 8'hD0);
        in_valid = 1'b1;
        in_data = 8'hDF;
        out_ready = 1'b1;
        #1;
        chk("ppfull.in_ready", 32'(in_ready), 32'd0);
        @(posedge aclk);
        #1;
        chk("ppfull.count", 32'(count), 32'd3);
        chk("ppfull.full", 32'(full), 32'd0);
        @(negedge aclk);
        in_valid = 1'b0;
        out_ready = 1'b0;

        // output stall while pushes continue
        reset_dut();
        in_valid = 1'b1;
        in_data = 8'hA0;
        @(negedge aclk);
        in_data = 8'hA1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            in_data = 8'hA2 + 8'(i);
            @(posedge aclk);
            #1;
            chk($sformatf("stall%0d.out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d.out_data", i), 32'(out_data), 32'hA0);
        end
        @(negedge aclk);
        in_valid = 1'b0;

        // asynchronous reset mid-burst
        reset_dut();
        push_until(3'd2, 1'b0, 8'hE0);
        in_valid = 1'b1;
        in_data = 8'hEE;
        #2;
        arst = 1'b1;
        #1;
        chk("arst.empty", 32'(empty), 32'd1);
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        chk("arst.count", 32'(count), 32'd0);
        in_valid = 1'b0;
        @(negedge aclk);
        arst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h55;
        @(negedge aclk);
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (out_valid) begin
                chk("arst.first_data", 32'(out_data), 32'h55);
                got = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        chk("arst.first_seen", 32'(got), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
